// File: rtl/demosaic_mhc_pipe.sv
`default_nettype none
// ============================================================================
//  demosaic_mhc_pipe
//  Malvar-He-Cutler 5x5 Bayer demosaic with a stall-able pipeline.
//  Rev 1.0 - initial release
// ============================================================================
module demosaic_mhc_pipe #(
  parameter int PW    = 10,
  parameter int IMG_W = 640,
  parameter int BAYER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [25*PW-1:0] in_win,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [PW-1:0]    out_r,
  output logic [PW-1:0]    out_g,
  output logic [PW-1:0]    out_b,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int                   CW         = $clog2(IMG_W);
  localparam int                   SW         = PW + 8;
  localparam logic [1:0]           c_BAYER    = BAYER[1:0];
  localparam logic [CW-1:0]        c_COL_LAST = CW'(IMG_W - 1);
  localparam logic signed [SW-1:0] c_PMAX     = SW'((1 << PW) - 1);
  localparam logic [1:0]           c_SITE_R   = 2'b00;
  localparam logic [1:0]           c_SITE_GR  = 2'b01;
  localparam logic [1:0]           c_SITE_GB  = 2'b10;
  localparam logic [1:0]           c_SITE_B   = 2'b11;

  logic          w_en;
  logic          w_accept;
  logic [CW-1:0] r_col;
  logic          r_row;
  logic [CW-1:0] w_col_cur;
  logic          w_row_cur;

  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign w_accept  = in_valid && w_en;
  // A start-of-frame window is (row 0, col 0) whatever the counters say.
  assign w_col_cur = in_sof ? '0 : r_col;
  assign w_row_cur = in_sof ? 1'b0 : r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= 1'b0;
    end else if (w_accept) begin
      if (w_col_cur == c_COL_LAST) begin
        r_col <= '0;
        r_row <= ~w_row_cur;
      end else begin
        r_col <= w_col_cur + CW'(1);
        r_row <= w_row_cur;
      end
    end
  end

  logic             r_s1_valid;
  logic [25*PW-1:0] r_s1_win;
  logic [1:0]       r_s1_site;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_win   <= in_win;
      r_s1_site  <= {w_row_cur ^ c_BAYER[1], w_col_cur[0] ^ c_BAYER[0]};
    end
  end

  logic signed [SW-1:0] w_d [1:5][1:5];

  for (genvar gi = 1; gi <= 5; gi++) begin : g_row
    for (genvar gj = 1; gj <= 5; gj++) begin : g_col
      assign w_d[gi][gj] = $signed({8'd0, r_s1_win[((gi-1)*5+(gj-1))*PW +: PW]});
    end
  end

  // Corner and off-axis taps play no part in any kernel.
  logic w_unused;
  assign w_unused = ^{w_d[1][1], w_d[1][2], w_d[1][4], w_d[1][5], w_d[2][1], w_d[2][5],
                      w_d[4][1], w_d[4][5], w_d[5][1], w_d[5][2], w_d[5][4], w_d[5][5]};

  logic signed [SW-1:0] w_diag;
  logic signed [SW-1:0] w_far;
  logic signed [SW-1:0] w_gx;
  logic signed [SW-1:0] w_h;
  logic signed [SW-1:0] w_v;
  logic signed [SW-1:0] w_x;

  assign w_diag = w_d[2][2] + w_d[2][4] + w_d[4][2] + w_d[4][4];
  assign w_far  = w_d[1][3] + w_d[5][3] + w_d[3][1] + w_d[3][5];

  assign w_gx = (w_d[3][3] <<< 3)
              + ((w_d[2][3] + w_d[4][3] + w_d[3][2] + w_d[3][4]) <<< 2)
              - (w_far <<< 1);
  assign w_h  = (w_d[3][3] <<< 3) + (w_d[3][3] <<< 1)
              + ((w_d[3][2] + w_d[3][4]) <<< 3)
              - ((w_diag + w_d[3][1] + w_d[3][5]) <<< 1)
              + w_d[1][3] + w_d[5][3];
  assign w_v  = (w_d[3][3] <<< 3) + (w_d[3][3] <<< 1)
              + ((w_d[2][3] + w_d[4][3]) <<< 3)
              - ((w_diag + w_d[1][3] + w_d[5][3]) <<< 1)
              + w_d[3][1] + w_d[3][5];
  assign w_x  = (w_d[3][3] <<< 3) + (w_d[3][3] <<< 2)
              + (w_diag <<< 2)
              - ((w_far <<< 1) + w_far);

  logic                 r_s2_valid;
  logic [1:0]           r_s2_site;
  logic signed [SW-1:0] r_s2_gx;
  logic signed [SW-1:0] r_s2_h;
  logic signed [SW-1:0] r_s2_v;
  logic signed [SW-1:0] r_s2_x;
  logic signed [SW-1:0] r_s2_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_site  <= r_s1_site;
      r_s2_gx    <= w_gx;
      r_s2_h     <= w_h;
      r_s2_v     <= w_v;
      r_s2_x     <= w_x;
      // Centre pre-scaled by 16 so pass-through shares the floor/clamp path.
      r_s2_c     <= w_d[3][3] <<< 4;
    end
  end

  logic signed [SW-1:0] w_sel_r;
  logic signed [SW-1:0] w_sel_g;
  logic signed [SW-1:0] w_sel_b;

  always_comb begin
    w_sel_r = r_s2_c;
    w_sel_g = r_s2_gx;
    w_sel_b = r_s2_x;
    case (r_s2_site)
      c_SITE_R:  begin w_sel_r = r_s2_c; w_sel_g = r_s2_gx; w_sel_b = r_s2_x; end
      c_SITE_GR: begin w_sel_r = r_s2_h; w_sel_g = r_s2_c;  w_sel_b = r_s2_v; end
      c_SITE_GB: begin w_sel_r = r_s2_v; w_sel_g = r_s2_c;  w_sel_b = r_s2_h; end
      c_SITE_B:  begin w_sel_r = r_s2_x; w_sel_g = r_s2_gx; w_sel_b = r_s2_c; end
      default:   begin w_sel_r = r_s2_c; w_sel_g = r_s2_gx; w_sel_b = r_s2_x; end
    endcase
  end

  logic                 r_s3_valid;
  logic signed [SW-1:0] r_s3_r;
  logic signed [SW-1:0] r_s3_g;
  logic signed [SW-1:0] r_s3_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_s3_r     <= w_sel_r;
      r_s3_g     <= w_sel_g;
      r_s3_b     <= w_sel_b;
    end
  end

  function automatic logic [PW-1:0] f_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    q = s >>> 4;
    if (q < 0)           return '0;
    else if (q > c_PMAX) return '1;
    else                 return q[PW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (w_en) begin
      out_valid <= r_s3_valid;
      out_r     <= f_sat(r_s3_r);
      out_g     <= f_sat(r_s3_g);
      out_b     <= f_sat(r_s3_b);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demosaic_mhc_pipe.sv
`default_nettype none
// Directed bench for demosaic_mhc_pipe: two instances (RGGB and BGGR, 6-pixel
// lines) share stimulus; outputs are collected on every output transfer.
module tb_demosaic_mhc_pipe;
  localparam int PW = 10;
  localparam int WW = 25 * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] in_win = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [PW-1:0] r0, g0, b0, r1, g1, b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3*PW-1:0] q0[$];
  logic [3*PW-1:0] q1[$];

  always #5 clk = ~clk;

  demosaic_mhc_pipe #(.PW(PW), .IMG_W(6), .BAYER(0)) dut0 (
    .clk(clk), .rst(rst), .in_win(in_win), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready0), .out_r(r0), .out_g(g0), .out_b(b0),
    .out_valid(out_valid0), .out_ready(out_ready));

  demosaic_mhc_pipe #(.PW(PW), .IMG_W(6), .BAYER(3)) dut1 (
    .clk(clk), .rst(rst), .in_win(in_win), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready1), .out_r(r1), .out_g(g1), .out_b(b1),
    .out_valid(out_valid1), .out_ready(out_ready));

  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid0) q0.push_back({r0, g0, b0});
      if (out_valid1) q1.push_back({r1, g1, b1});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WW-1:0] px(input logic [WW-1:0] w, input int i, input int j, input int v);
    w[((i-1)*5+(j-1))*PW +: PW] = PW'(v);
    return w;
  endfunction

  function automatic logic [WW-1:0] flat(input int v);
    logic [WW-1:0] w;
    for (int k = 0; k < 25; k++) w[k*PW +: PW] = PW'(v);
    return w;
  endfunction

  // D33=160, D32=D34=16: GX=88, H=116, V=100, X=120, so every site differs.
  function automatic logic [WW-1:0] probe();
    logic [WW-1:0] w;
    w = '0;
    w = px(w, 3, 3, 160);
    w = px(w, 3, 2, 16);
    w = px(w, 3, 4, 16);
    return w;
  endfunction

  function automatic logic [3*PW-1:0] site_rgb(input int s);
    case (s)
      0:       return {10'd160, 10'd88,  10'd120};
      1:       return {10'd116, 10'd160, 10'd100};
      2:       return {10'd100, 10'd160, 10'd116};
      default: return {10'd120, 10'd88,  10'd160};
    endcase
  endfunction

  task automatic send(input logic [WW-1:0] w, input logic sof);
    int n;
    n = 0;
    in_win   = w;
    in_sof   = sof;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int t;
    t = 0;
    while ((q0.size() < n || q1.size() < n) && t < 100) begin
      @(posedge clk);
      t++;
    end
    n_tests++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL wait_outputs: got %0d/%0d outputs, required %0d", q0.size(), q1.size(), n);
    end
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_win = flat(7); out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid0); end
    n_tests++; if ({r0, g0, b0} !== '0) begin n_fail++; $display("FAIL reset_rgb: got %h, required 0", {r0, g0, b0}); end
    n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready0); end
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b, required 0", out_valid1); end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL reset_no_output: got %0d outputs, required 0", q0.size()); end
  endtask

  task automatic test_flat();
    flush();
    send(flat(512), 1'b1);
    @(negedge clk);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL latency_n0: got %b, required 0", out_valid0); end
    @(negedge clk);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL latency_n1: got %b, required 0", out_valid0); end
    @(negedge clk);
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL latency_n2: got %b, required 0", out_valid0); end
    @(negedge clk);
    n_tests++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL latency_n3: got %b, required 1", out_valid0); end
    n_tests++; if ({r0, g0, b0} !== {10'd512, 10'd512, 10'd512}) begin n_fail++; $display("FAIL flat_first: got %h, required %h", {r0, g0, b0}, {10'd512, 10'd512, 10'd512}); end
    for (int i = 0; i < 8; i++) send(flat(512), 1'b0);
    wait_q(9);
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (q0[i] !== {10'd512, 10'd512, 10'd512} || q1[i] !== {10'd512, 10'd512, 10'd512}) begin
        n_fail++; $display("FAIL flat_%0d: got %h/%h, required %h", i, q0[i], q1[i], {10'd512, 10'd512, 10'd512});
      end
    end
  endtask

  task automatic test_saturation();
    logic [WW-1:0] w;
    flush();
    w = '0;
    w = px(w, 1, 3, 1023); w = px(w, 5, 3, 1023); w = px(w, 3, 1, 1023); w = px(w, 3, 5, 1023);
    send(w, 1'b1);
    w = '0;
    w = px(w, 3, 2, 1023); w = px(w, 3, 4, 1023); w = px(w, 1, 3, 1023); w = px(w, 5, 3, 1023);
    send(w, 1'b0);
    wait_q(2);
    n_tests++; if (q0[0] !== {10'd0, 10'd0, 10'd0}) begin n_fail++; $display("FAIL sat_low_rsite: got %h, required %h", q0[0], 30'd0); end
    n_tests++; if (q0[1] !== {10'd1023, 10'd0, 10'd0}) begin n_fail++; $display("FAIL sat_high_gr: got %h, required %h", q0[1], {10'd1023, 10'd0, 10'd0}); end
  endtask

  task automatic test_rounding();
    logic [WW-1:0] w;
    flush();
    send('0, 1'b1);
    w = '0; w = px(w, 3, 3, 1); w = px(w, 1, 3, 1);
    send(w, 1'b0);
    send('0, 1'b0);
    w = '0; w = px(w, 3, 3, 2);
    send(w, 1'b0);
    wait_q(4);
    n_tests++; if (q0[1] !== {10'd0, 10'd1, 10'd0}) begin n_fail++; $display("FAIL round_s11: got %h, required %h", q0[1], {10'd0, 10'd1, 10'd0}); end
    n_tests++; if (q0[3] !== {10'd1, 10'd2, 10'd1}) begin n_fail++; $display("FAIL round_s20: got %h, required %h", q0[3], {10'd1, 10'd2, 10'd1}); end
  endtask

  task automatic test_phase_walk();
    int exp0 [15] = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3, 0, 0, 1};
    int exp1 [15] = '{3, 2, 3, 2, 3, 2, 1, 0, 1, 0, 1, 0, 3, 3, 2};
    flush();
    // Window 13 carries a mid-line sof at col 1 and must restart at col 0.
    for (int k = 0; k < 15; k++) send(probe(), (k == 0) || (k == 13));
    wait_q(15);
    for (int k = 0; k < 15; k++) begin
      n_tests++;
      if (q1[k] !== site_rgb(exp1[k])) begin
        n_fail++; $display("FAIL phase_bggr_%0d: got %h, required %h", k, q1[k], site_rgb(exp1[k]));
      end
      n_tests++;
      if (q0[k] !== site_rgb(exp0[k])) begin
        n_fail++; $display("FAIL phase_rggb_%0d: got %h, required %h", k, q0[k], site_rgb(exp0[k]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3*PW-1:0] snap;
    logic [3*PW-1:0] ev;
    flush();
    fork
      begin
        for (int i = 0; i < 10; i++) send(flat(100 + 37 * i), i == 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap = {r0, g0, b0};
        n_tests++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b, required 1", out_valid0); end
        n_tests++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_0: got %b, required 0", in_ready0); end
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          n_tests++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d: got %b, required 0", k, in_ready0); end
          n_tests++; if ({r0, g0, b0} !== snap || out_valid0 !== 1'b1) begin n_fail++; $display("FAIL stall_hold_%0d: got %h v=%b, required %h v=1", k, {r0, g0, b0}, out_valid0, snap); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_q(10);
    repeat (6) @(posedge clk);
    n_tests++; if (q0.size() !== 10) begin n_fail++; $display("FAIL bp_count: got %0d outputs, required 10", q0.size()); end
    for (int i = 0; i < 10; i++) begin
      ev = {PW'(100 + 37 * i), PW'(100 + 37 * i), PW'(100 + 37 * i)};
      n_tests++;
      if (q0[i] !== ev) begin n_fail++; $display("FAIL bp_order_%0d: got %h, required %h", i, q0[i], ev); end
    end
  endtask

  task automatic test_reset_midstream();
    flush();
    send(flat(300), 1'b1);
    send(flat(301), 1'b0);
    send(flat(302), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", out_valid0); end
    n_tests++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready0); end
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (q0.size() !== 0) begin n_fail++; $display("FAIL midrst_discard: got %0d outputs, required 0", q0.size()); end
    send(probe(), 1'b0);
    send(probe(), 1'b0);
    send(probe(), 1'b1);
    wait_q(3);
    n_tests++; if (q0[0] !== site_rgb(0) || q1[0] !== site_rgb(3)) begin n_fail++; $display("FAIL midrst_col0: got %h/%h, required %h/%h", q0[0], q1[0], site_rgb(0), site_rgb(3)); end
    n_tests++; if (q0[1] !== site_rgb(1) || q1[1] !== site_rgb(2)) begin n_fail++; $display("FAIL midrst_col1: got %h/%h, required %h/%h", q0[1], q1[1], site_rgb(1), site_rgb(2)); end
    n_tests++; if (q0[2] !== site_rgb(0) || q1[2] !== site_rgb(3)) begin n_fail++; $display("FAIL midrst_sof: got %h/%h, required %h/%h", q0[2], q1[2], site_rgb(0), site_rgb(3)); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_saturation();
    test_rounding();
    test_phase_walk();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
